// File: rtl/rf_multiport_if.sv
// Register-file bus: read ports, issue (rename) port, commit ports, throttle count.
// The master is the core side that drives ids, tags and commit data. The slave is the
// register file.
// There is no valid/ready handshake on this bus. Every input is sampled on each clk_in edge
// where rdy_in is high. An id of 0 marks an idle issue or commit slot. rdy_in is a global
// stall, and reads are combinational and always available.
interface rf_multiport_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int RIDX_W = 4,
    parameter int NRD    = 2,
    parameter int NCMT   = 2
);
    localparam int DCNT_W = $clog2(NREG) + 1;

    logic                   rdy_in;
    logic                   clear;
    logic [NRD*5-1:0]       rd_id;
    logic [NRD*XLEN-1:0]    rd_val;
    logic [NRD*RIDX_W-1:0]  rd_dep;
    logic [NRD-1:0]         rd_has_dep;
    logic [4:0]             iss_id;
    logic [RIDX_W-1:0]      iss_tag;
    logic [NCMT*5-1:0]      cmt_id;
    logic [NCMT*XLEN-1:0]   cmt_val;
    logic [NCMT*RIDX_W-1:0] cmt_tag;
    logic [DCNT_W-1:0]      dep_cnt;

    modport master (
        output rdy_in, clear, rd_id, iss_id, iss_tag, cmt_id, cmt_val, cmt_tag,
        input  rd_val, rd_dep, rd_has_dep, dep_cnt
    );

    modport slave (
        input  rdy_in, clear, rd_id, iss_id, iss_tag, cmt_id, cmt_val, cmt_tag,
        output rd_val, rd_dep, rd_has_dep, dep_cnt
    );
endinterface

// File: rtl/rf_multiport.sv
// Architectural register file with a ROB dependency tag on each register.
// It has NRD combinational read ports, one rename per cycle and NCMT commits per cycle.
// x0 is hardwired to zero and never carries a dependency.
// Build option: define RF_COMMIT_BYPASS_EN to forward same-cycle releasing commits to reads.
// Register ids are 5 bits wide, so NREG is expected to be 32.
module rf_multiport #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int RIDX_W = 4,
    parameter int NRD    = 2,
    parameter int NCMT   = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    rf_multiport_if.slave     bus
);
    localparam int DCNT_W = $clog2(NREG) + 1;

    logic [XLEN-1:0]   val_q [NREG];
    logic [RIDX_W-1:0] dep_q [NREG];
    logic [NREG-1:0]   has_q;
    logic [DCNT_W-1:0] cnt_q;

    logic [XLEN-1:0]   val_n [NREG];
    logic [RIDX_W-1:0] dep_n [NREG];
    logic [NREG-1:0]   has_n;
    logic [DCNT_W-1:0] cnt_n;

    logic [4:0]        cmt_idx [NCMT];
    logic [NCMT-1:0]   cmt_ok;
    logic [NCMT-1:0]   cmt_rel;

    // A commit releases when its tag matches the live dep, unless that reg is renamed this cycle.
    always_comb begin
        for (int c = 0; c < NCMT; c++) begin
            cmt_idx[c] = bus.cmt_id[c*5 +: 5];
            cmt_ok[c]  = (cmt_idx[c] != 5'd0);
            cmt_rel[c] = cmt_ok[c] && has_q[cmt_idx[c]]
                         && (dep_q[cmt_idx[c]] == bus.cmt_tag[c*RIDX_W +: RIDX_W])
                         && (bus.iss_id != cmt_idx[c]);
        end
    end

    // Next state: commit values in port order, then releases, then clear or issue on top.
    always_comb begin
        val_n = val_q;
        dep_n = dep_q;
        has_n = has_q;
        cnt_n = '0;
        for (int c = 0; c < NCMT; c++) begin
            if (cmt_ok[c]) val_n[cmt_idx[c]] = bus.cmt_val[c*XLEN +: XLEN];
        end
        for (int c = 0; c < NCMT; c++) begin
            if (cmt_rel[c]) has_n[cmt_idx[c]] = 1'b0;
        end
        if (bus.clear) begin
            for (int r = 0; r < NREG; r++) dep_n[r] = '0;
            has_n = '0;
        end else if (bus.iss_id != 5'd0) begin
            dep_n[bus.iss_id] = bus.iss_tag;
            has_n[bus.iss_id] = 1'b1;
        end
        for (int r = 0; r < NREG; r++) cnt_n = cnt_n + DCNT_W'(has_n[r]);
    end

    // State update: reset wins over the stall, and the stall freezes everything.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r] <= '0;
                dep_q[r] <= '0;
            end
            has_q <= '0;
            cnt_q <= '0;
        end else if (bus.rdy_in) begin
            for (int r = 0; r < NREG; r++) begin
                val_q[r] <= (r == 0) ? '0 : val_n[r];
                dep_q[r] <= dep_n[r];
            end
            has_q <= has_n;
            cnt_q <= cnt_n;
        end
    end

    // Combinational read ports, with an optional bypass of releasing commits.
    always_comb begin
        logic [4:0]        id;
        logic [XLEN-1:0]   v;
        logic              h;
        bus.rd_val     = '0;
        bus.rd_dep     = '0;
        bus.rd_has_dep = '0;
        for (int k = 0; k < NRD; k++) begin
            id = bus.rd_id[k*5 +: 5];
            v  = (id == 5'd0) ? '0 : val_q[id];
            h  = (id != 5'd0) && has_q[id];
`ifdef RF_COMMIT_BYPASS_EN
            for (int c = 0; c < NCMT; c++) begin
                if (cmt_rel[c] && (cmt_idx[c] == id)) begin
                    v = bus.cmt_val[c*XLEN +: XLEN];
                    h = 1'b0;
                end
            end
`endif
            bus.rd_val[k*XLEN +: XLEN]     = v;
            bus.rd_dep[k*RIDX_W +: RIDX_W] = dep_q[id];
            bus.rd_has_dep[k]              = h;
        end
    end

    assign bus.dep_cnt = cnt_q;
endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport. Expected values are hand-computed, and every check
// is an immediate assertion.
module tb_rf_multiport;
    localparam int XLEN = 32, NREG = 32, RIDX_W = 4, NRD = 2, NCMT = 2;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rf_multiport_if #(.XLEN(XLEN), .NREG(NREG), .RIDX_W(RIDX_W), .NRD(NRD), .NCMT(NCMT)) bus ();

    rf_multiport #(.XLEN(XLEN), .NREG(NREG), .RIDX_W(RIDX_W), .NRD(NRD), .NCMT(NCMT)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    // clock/reset block
    always #5 clk_in = ~clk_in;

    // driver tasks
    task automatic idle();
        bus.rdy_in  = 1'b1;
        bus.clear   = 1'b0;
        bus.iss_id  = '0;
        bus.iss_tag = '0;
        bus.cmt_id  = '0;
        bus.cmt_val = '0;
        bus.cmt_tag = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic rd(input int port, input logic [4:0] id);
        bus.rd_id[port*5 +: 5] = id;
    endtask

    task automatic issue(input logic [4:0] id, input logic [RIDX_W-1:0] tag);
        bus.iss_id  = id;
        bus.iss_tag = tag;
    endtask

    task automatic commit(input int port, input logic [4:0] id, input logic [XLEN-1:0] v,
                          input logic [RIDX_W-1:0] tag);
        bus.cmt_id[port*5 +: 5]            = id;
        bus.cmt_val[port*XLEN +: XLEN]     = v;
        bus.cmt_tag[port*RIDX_W +: RIDX_W] = tag;
    endtask

    // scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] val_p(input int port);
        return bus.rd_val[port*XLEN +: XLEN];
    endfunction

    function automatic logic [31:0] has_p(input int port);
        return 32'(bus.rd_has_dep[port]);
    endfunction

    function automatic logic [31:0] dep_p(input int port);
        return 32'(bus.rd_dep[port*RIDX_W +: RIDX_W]);
    endfunction

    initial begin
        idle();
        bus.rd_id = '0;
        rst_n_in  = 1'b0;
        step();
        step();
        rst_n_in = 1'b1;
        rd(0, 5'd5);
        #1;
        check("reset_val", val_p(0), 32'h0);
        check("reset_has", has_p(0), 32'h0);
        check("reset_cnt", 32'(bus.dep_cnt), 32'h0);

        // Issue x3 with tag 7, then a matching commit releases it.
        issue(5'd3, 4'd7);
        rd(0, 5'd3);
        step();
        check("iss3_cnt", 32'(bus.dep_cnt), 32'd1);
        check("iss3_has", has_p(0), 32'd1);
        check("iss3_dep", dep_p(0), 32'd7);
        idle();
        commit(0, 5'd3, 32'hDEAD, 4'd7);
        step();
        idle();
        check("cmt3_val", val_p(0), 32'hDEAD);
        check("cmt3_has", has_p(0), 32'd0);
        check("cmt3_cnt", 32'(bus.dep_cnt), 32'd0);

        // In the same cycle, a rename beats a release. The value is still written.
        issue(5'd4, 4'd1);
        step();
        issue(5'd4, 4'd2);
        commit(0, 5'd4, 32'h44, 4'd1);
        rd(1, 5'd4);
        step();
        idle();
        check("x4_val", val_p(1), 32'h44);
        check("x4_dep", dep_p(1), 32'd2);
        check("x4_has", has_p(1), 32'd1);
        check("x4_cnt", 32'(bus.dep_cnt), 32'd1);

        // Dual commit to x6: port 1 wins the value, and the tag-4 commit releases.
        issue(5'd6, 4'd4);
        step();
        idle();
        commit(0, 5'd6, 32'd1, 4'd3);
        commit(1, 5'd6, 32'd2, 4'd4);
        rd(0, 5'd6);
        step();
        idle();
        check("x6a_val", val_p(0), 32'd2);
        check("x6a_has", has_p(0), 32'd0);
        check("x6a_cnt", 32'(bus.dep_cnt), 32'd1);
        // With stored dep 5, neither commit matches. This is the stale rename case.
        issue(5'd6, 4'd5);
        step();
        idle();
        commit(0, 5'd6, 32'd1, 4'd3);
        commit(1, 5'd6, 32'd2, 4'd4);
        step();
        idle();
        check("x6b_val", val_p(0), 32'd2);
        check("x6b_has", has_p(0), 32'd1);
        check("x6b_cnt", 32'(bus.dep_cnt), 32'd2);

        // A write or rename of x0 has no effect.
        commit(0, 5'd0, 32'hFFFF, 4'd0);
        issue(5'd0, 4'd3);
        rd(1, 5'd0);
        step();
        idle();
        check("x0_val", val_p(1), 32'h0);
        check("x0_has", has_p(1), 32'h0);
        check("x0_cnt", 32'(bus.dep_cnt), 32'd2);

        // Make three deps live: x4, x6 and x7.
        issue(5'd7, 4'd1);
        step();
        idle();
        check("live3_cnt", 32'(bus.dep_cnt), 32'd3);

        // With rdy_in low, the clear, commit and issue change nothing.
        bus.rdy_in = 1'b0;
        bus.clear  = 1'b1;
        commit(0, 5'd8, 32'd9, 4'd0);
        issue(5'd10, 4'd3);
        rd(0, 5'd8);
        rd(1, 5'd4);
        step();
        check("frz_x8", val_p(0), 32'd0);
        check("frz_x4has", has_p(1), 32'd1);
        check("frz_cnt", 32'(bus.dep_cnt), 32'd3);
        // With rdy_in high, the same stimulus clears all deps and still writes x8.
        bus.rdy_in = 1'b1;
        step();
        idle();
        check("clr_x8", val_p(0), 32'd9);
        check("clr_x4has", has_p(1), 32'd0);
        check("clr_cnt", 32'(bus.dep_cnt), 32'd0);
        rd(1, 5'd10);
        #1;
        check("clr_x10has", has_p(1), 32'd0);

        // Same-cycle read of a releasing commit.
        commit(0, 5'd9, 32'h11, 4'd0);
        step();
        idle();
        issue(5'd9, 4'd5);
        step();
        idle();
        commit(1, 5'd9, 32'h55, 4'd5);
        rd(0, 5'd9);
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        check("byp_val", val_p(0), 32'h55);
        check("byp_has", has_p(0), 32'd0);
`else
        check("byp_val", val_p(0), 32'h11);
        check("byp_has", has_p(0), 32'd1);
`endif
        step();
        idle();
        check("post_val", val_p(0), 32'h55);
        check("post_has", has_p(0), 32'd0);
        check("post_cnt", 32'(bus.dep_cnt), 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
